// File: rtl/sd_pkg.sv
// Shared SD path definitions: SPI engine state encoding and default clocking constants.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    XFER = 2'd2
  } sd_spi_state_t;

  // 100 MHz system clock: 400 kHz card-init clock, 25 MHz data clock
  localparam int unsigned SD_SLOW_DIV    = 125;
  localparam int unsigned SD_FAST_DIV    = 2;
  localparam int unsigned SD_INIT_CLOCKS = 80;

  function automatic int unsigned sd_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sd_sclk_gen.sv
// SCLK half-period generator: counts to a latched divider and emits one-cycle rise/fall strobes.
module sd_sclk_gen #(
  parameter int unsigned DIV_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_m1_i,
  input  logic             run_i,
  output logic             sclk_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [DIV_W-1:0] div_m1_q, div_m1_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             sclk_q, sclk_d;
  logic             wrap;

  assign wrap   = (cnt_q == div_m1_q);
  assign rise_o = run_i && wrap && !sclk_q;
  assign fall_o = run_i && wrap && sclk_q;
  assign sclk_o = sclk_q;

  // The divider is stored as D-1 so the largest divider still fits the counter width
  always_comb begin
    div_m1_d = div_m1_q;
    cnt_d    = cnt_q;
    sclk_d   = sclk_q;
    if (load_i) begin
      div_m1_d = div_m1_i;
      cnt_d    = '0;
      sclk_d   = 1'b0;
    end else if (run_i) begin
      if (wrap) begin
        cnt_d  = '0;
        sclk_d = ~sclk_q;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_m1_q <= '0;
      cnt_q    <= '0;
      sclk_q   <= 1'b0;
    end else begin
      div_m1_q <= div_m1_d;
      cnt_q    <= cnt_d;
      sclk_q   <= sclk_d;
    end
  end

endmodule

// File: rtl/sd_spi_engine.sv
// SD card SPI byte engine: power-up dummy clocks and full-duplex mode-0 byte shifting.
// State table: IDLE | ready for a byte or init request ; INIT | dummy clocks, CS/MOSI high ;
//              XFER | shifting one byte, CS low
module sd_spi_engine
  import sd_pkg::*;
#(
  parameter int unsigned SLOW_DIV    = SD_SLOW_DIV,
  parameter int unsigned FAST_DIV    = SD_FAST_DIV,
  parameter int unsigned INIT_CLOCKS = SD_INIT_CLOCKS
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic       fast_mode,
  input  logic       start_init,
  output logic       init_done,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       cs_hold,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       sd_sclk,
  output logic       sd_mosi,
  output logic       sd_cs_n,
  input  logic       sd_miso
);

  localparam int unsigned DIV_W  = $clog2(sd_max(SLOW_DIV, FAST_DIV));
  localparam int unsigned INIT_W = $clog2(INIT_CLOCKS) + 1;
  localparam logic [DIV_W-1:0]  SLOW_M1   = DIV_W'(SLOW_DIV - 1);
  localparam logic [DIV_W-1:0]  FAST_M1   = DIV_W'(FAST_DIV - 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CLOCKS - 1);

  sd_spi_state_t     state_q, state_d;
  logic [7:0]        tx_sr_q, tx_sr_d;
  logic [7:0]        rx_sr_q, rx_sr_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic              cs_n_q, cs_n_d;
  logic              mosi_q, mosi_d;
  logic              init_done_q, init_done_d;
  logic              rx_valid_q, rx_valid_d;

  logic              gen_load;
  logic [DIV_W-1:0]  gen_div_m1;
  logic              gen_run;
  logic              gen_rise;
  logic              gen_fall;

  assign gen_run = (state_q != IDLE);

  sd_sclk_gen #(
    .DIV_W (DIV_W)
  ) u_sclk_gen (
    .clk      (clk),
    .rst_n    (sys_rst_n),
    .load_i   (gen_load),
    .div_m1_i (gen_div_m1),
    .run_i    (gen_run),
    .sclk_o   (sd_sclk),
    .rise_o   (gen_rise),
    .fall_o   (gen_fall)
  );

  always_comb begin
    state_d     = state_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    bit_cnt_d   = bit_cnt_q;
    init_cnt_d  = init_cnt_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    init_done_d = init_done_q;
    rx_valid_d  = 1'b0;
    gen_load    = 1'b0;
    gen_div_m1  = SLOW_M1;
    unique case (state_q)
      IDLE: begin
        // init request has priority; the pending byte waits until init completes
        if (start_init) begin
          state_d     = INIT;
          gen_load    = 1'b1;
          gen_div_m1  = SLOW_M1;
          init_cnt_d  = '0;
          init_done_d = 1'b0;
          cs_n_d      = 1'b1;
          mosi_d      = 1'b1;
        end else if (tx_valid) begin
          state_d    = XFER;
          gen_load   = 1'b1;
          gen_div_m1 = fast_mode ? FAST_M1 : SLOW_M1;
          tx_sr_d    = tx_data;
          bit_cnt_d  = '0;
          cs_n_d     = 1'b0;
          mosi_d     = tx_data[7];
        end
      end
      INIT: begin
        if (gen_fall) begin
          if (init_cnt_q == INIT_LAST) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
          end else begin
            init_cnt_d = init_cnt_q + INIT_W'(1);
          end
        end
      end
      XFER: begin
        if (gen_rise) begin
          rx_sr_d = {rx_sr_q[6:0], sd_miso};
        end
        if (gen_fall) begin
          if (bit_cnt_q == 3'd7) begin
            state_d    = IDLE;
            rx_valid_d = 1'b1;
            cs_n_d     = ~cs_hold;
            mosi_d     = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_sr_d   = {tx_sr_q[6:0], 1'b0};
            mosi_d    = tx_sr_q[6];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      init_cnt_q  <= '0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b1;
      init_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      init_cnt_q  <= init_cnt_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      init_done_q <= init_done_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign tx_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign init_done = init_done_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_sr_q;
  assign sd_mosi   = mosi_q;
  assign sd_cs_n   = cs_n_q;

endmodule

// File: tb/tb_sd_spi_engine.sv
// Bench for sd_spi_engine: scoreboard of expected bytes and completion cycles, MISO looped from MOSI.
module tb_sd_spi_engine;

  localparam int SLOW  = 125;
  localparam int FAST  = 2;
  localparam int INITC = 80;

  logic       clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       fast_mode = 1'b0;
  logic       start_init = 1'b0;
  logic       tx_valid = 1'b0;
  logic       cs_hold = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       init_done, tx_ready, rx_valid, busy;
  logic       sd_sclk, sd_mosi, sd_cs_n, sd_miso;
  logic [7:0] rx_data;
  bit         miso_inv = 1'b0;

  // card stand-in: echoes MOSI, optionally inverted
  assign sd_miso = miso_inv ? ~sd_mosi : sd_mosi;

  sd_spi_engine dut (
    .clk        (clk),
    .sys_rst_n  (sys_rst_n),
    .fast_mode  (fast_mode),
    .start_init (start_init),
    .init_done  (init_done),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .cs_hold    (cs_hold),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .busy       (busy),
    .sd_sclk    (sd_sclk),
    .sd_mosi    (sd_mosi),
    .sd_cs_n    (sd_cs_n),
    .sd_miso    (sd_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t sb[$];

  int seg_id = 0;
  int cur_d  = SLOW;

  int mon_seg = -1;
  int seg_rises = 0;
  bit have_last = 0;
  int last_rise = 0;
  logic sclk_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: SCLK period and rise count per segment, received bytes against the scoreboard
  always @(negedge clk) begin
    if (sys_rst_n) begin
      if (sd_sclk && !sclk_prev) begin
        if (mon_seg != seg_id) begin
          mon_seg   = seg_id;
          seg_rises = 0;
          have_last = 0;
        end
        if (have_last) chk("sclk_period", cyc - last_rise, 2 * cur_d);
        have_last = 1;
        last_rise = cyc;
        seg_rises++;
      end
      if (rx_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rx_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rx_data", rx_data, e.data);
          chk("rx_latency", cyc, e.due);
          chk("rx_rises", seg_rises, 8);
        end
      end
    end
    sclk_prev = sd_sclk;
  end

  // issue one byte; called at a negedge, returns at the negedge of the accept cycle
  task automatic send(input logic [7:0] d, input bit fm, input bit hold, input bit inv,
                      output int t0);
    int   n;
    exp_t e;
    n = 0;
    tx_data = d; tx_valid = 1'b1; fast_mode = fm; cs_hold = hold; miso_inv = inv;
    while (!(tx_ready && !start_init) && n < 25000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", n < 25000, 1);
    t0     = cyc + 1;
    seg_id = seg_id + 1;
    cur_d  = fm ? FAST : SLOW;
    e.data = inv ? ~d : d;
    e.due  = t0 + 16 * cur_d;
    sb.push_back(e);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(input logic exp_cs);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_valid && n < 5000);
    chk("rx_timeout", n < 5000, 1);
    chk("cs_at_byte_end", sd_cs_n, exp_cs);
    chk("ready_at_byte_end", tx_ready, 1);
  endtask

  task automatic run_init(input bit with_tx, input logic [7:0] d, output int ts);
    int n;
    bit bad_pins, bad_ready;
    n = 0; bad_pins = 0; bad_ready = 0;
    fast_mode  = 1'b1;
    start_init = 1'b1;
    if (with_tx) begin
      tx_valid = 1'b1; tx_data = d; cs_hold = 1'b0; miso_inv = 1'b0;
    end
    ts     = cyc + 1;
    seg_id = seg_id + 1;
    cur_d  = SLOW;
    @(negedge clk);
    start_init = 1'b0;
    chk("init_done_cleared", init_done, 0);
    while (!init_done && n < 21000) begin
      if (sd_cs_n !== 1'b1 || sd_mosi !== 1'b1) bad_pins = 1;
      if (tx_ready !== 1'b0 || busy !== 1'b1) bad_ready = 1;
      @(negedge clk);
      n++;
    end
    chk("init_timeout", n < 21000, 1);
    chk("init_cs_mosi_high", bad_pins, 0);
    chk("init_not_ready", bad_ready, 0);
    chk("init_length", cyc - ts, 2 * SLOW * INITC);
    chk("init_rises", seg_rises, INITC);
    chk("init_ready_after", tx_ready, 1);
  endtask

  initial begin
    int t0, t0b, ts, n;
    bit bad, seen;
    logic [7:0] d;
    bit fm, hold, inv;

    repeat (3) @(negedge clk);
    chk("rst_sclk", sd_sclk, 0);
    chk("rst_mosi", sd_mosi, 1);
    chk("rst_cs_n", sd_cs_n, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_busy", busy, 0);
    sys_rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", tx_ready, 1);
    chk("post_rst_cs_n", sd_cs_n, 1);

    // fast loopback
    send(8'hA5, 1'b1, 1'b0, 1'b0, t0);
    chk("accept_cs_low", sd_cs_n, 0);
    chk("accept_mosi_bit7", sd_mosi, 1);
    chk("accept_sclk_low", sd_sclk, 0);
    wait_rx(1'b1);
    chk("fast_latency", cyc - t0, 32);
    chk("fast_rx", rx_data, 8'hA5);
    repeat (3) @(negedge clk);

    // power-up dummy clocks, fast_mode ignored
    run_init(1'b0, 8'h00, ts);
    repeat (2) @(negedge clk);

    // CS held across back-to-back bytes
    send(8'hFF, 1'b1, 1'b1, 1'b0, t0);
    bad = 0; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!rx_valid && sd_cs_n !== 1'b0) bad = 1;
    end while (!rx_valid && n < 100);
    chk("hold_first_rx_seen", rx_valid, 1);
    chk("hold_cs_at_first_end", sd_cs_n, 0);
    send(8'h00, 1'b1, 1'b0, 1'b0, t0b);
    chk("b2b_accept_cycle", t0b, t0 + 33);
    if (sd_cs_n !== 1'b0) bad = 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!rx_valid && sd_cs_n !== 1'b0) bad = 1;
    end while (!rx_valid && n < 100);
    chk("hold_cs_continuous", bad, 0);
    chk("hold_cs_release", sd_cs_n, 1);
    chk("hold_second_rx", rx_data, 8'h00);
    repeat (2) @(negedge clk);

    // start_init and tx_valid together: init first, then the byte
    run_init(1'b1, 8'h3C, ts);
    send(8'h3C, 1'b1, 1'b0, 1'b0, t0);
    chk("contention_accept_cycle", t0, ts + 2 * SLOW * INITC + 1);
    wait_rx(1'b1);
    chk("contention_init_held", init_done, 1);
    repeat (2) @(negedge clk);

    // randomized bytes, divider changes mid-byte must not matter
    for (int i = 0; i < 12; i++) begin
      d    = 8'($urandom);
      fm   = ($urandom_range(0, 3) != 0);
      hold = 1'($urandom_range(0, 1));
      inv  = 1'($urandom_range(0, 1));
      send(d, fm, hold, inv, t0);
      if ($urandom_range(0, 1) == 1) begin
        repeat (2) @(negedge clk);
        fast_mode = ~fm;
      end
      wait_rx(~hold);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // reset in the middle of bit 3
    send(8'h5A, 1'b1, 1'b0, 1'b0, t0);
    while (cyc < t0 + 14) @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    chk("midrst_sclk_before", sd_sclk, 1);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_sclk", sd_sclk, 0);
    chk("midrst_mosi", sd_mosi, 1);
    chk("midrst_cs_n", sd_cs_n, 1);
    chk("midrst_rx_valid", rx_valid, 0);
    chk("midrst_rx_data", rx_data, 0);
    chk("midrst_init_done", init_done, 0);
    chk("midrst_busy", busy, 0);
    if (sb.size() > 0) void'(sb.pop_back());
    seg_id = seg_id + 1;
    repeat (3) @(negedge clk);
    sys_rst_n = 1'b1;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (rx_valid) seen = 1;
    end
    chk("midrst_no_rx_valid", seen, 0);

    // slow-mode byte after recovery
    send(8'hC3, 1'b0, 1'b0, 1'b1, t0);
    wait_rx(1'b1);
    chk("slow_latency", cyc - t0, 16 * SLOW);
    repeat (2) @(negedge clk);

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/sd_spi_engine.md
# sd_spi_engine

SPI byte engine and clock sequencer for the SD card path. Generates the SD card SCLK from the system clock with a selectable slow (card init, 400 kHz) or fast (data, 25 MHz) divider. Runs the power-up dummy-clock sequence and shifts single bytes full-duplex under a valid/ready handshake. Sits between the SD command/data controller and the card pins, and is the sole owner of SCLK, MOSI and CS.

## Interface
- `SLOW_DIV`, default 125: system cycles per SCLK half-period in slow mode (100 MHz → 400 kHz).
- `FAST_DIV`, default 2: system cycles per SCLK half-period in fast mode (100 MHz → 25 MHz). Must be ≥ 2.
- `INIT_CLOCKS`, default 80: number of full SCLK periods in the init sequence. Must be ≥ 74.

Ports:
- `clk`  in  1  system clock. One clock domain; `clk` is the only clock.
- `sys_rst_n`  in  1  reset, asynchronous and active-low.
- `fast_mode`  in  1  1 = FAST_DIV, 0 = SLOW_DIV; sampled at byte accept.
- `start_init`  in  1  one-cycle request to run the init sequence.
- `init_done`  out  1  high after init completes; held until reset or the next `start_init`.
- `tx_valid` / `tx_ready`  in / out  1  byte handshake.
- `tx_data`  in  8  byte to send, MSB first.
- `cs_hold`  in  1  1 = keep CS low after the current byte.
- `rx_valid`  out  1  one-cycle pulse; `rx_data` is valid in that cycle.
- `rx_data`  out  8  received byte.
- `busy`  out  1  high in INIT or XFER.
- `sd_sclk`, `sd_mosi`, `sd_cs_n`  out  1  card pins.
- `sd_miso`  in  1  card pin, already synchronised upstream.

## Operation
- FSM states:
  - IDLE → INIT on `start_init`.
  - IDLE → XFER on `tx_valid && tx_ready`.
  - INIT → IDLE after INIT_CLOCKS periods.
  - XFER → IDLE after 8 bits.
- If `start_init` and `tx_valid` are both high in IDLE, INIT wins. The byte is not accepted and `tx_ready` drops.
- `tx_ready` = (state == IDLE). `busy` = !`tx_ready`.
- INIT:
  - `sd_cs_n`=1 and `sd_mosi`=1 throughout.
  - Always uses SLOW_DIV, regardless of `fast_mode`.
  - `init_done` clears on entry and sets in the cycle the FSM returns to IDLE.
- XFER uses SPI mode 0:
  - SCLK idles low.
  - MISO is sampled on the rising edge.
  - MOSI changes on the falling edge.
  - Bit 7 is presented at accept.
- The divider is latched at accept. A change to `fast_mode` mid-byte has no effect on that byte.
- CS handling:
  - `sd_cs_n` goes low at accept.
  - At byte end, `cs_hold` is sampled. If 0, `sd_cs_n` returns high in that cycle; if 1, it stays low.
  - In IDLE with CS held, the next accept keeps CS low.
- `rx_data` is a shift register, left-shifting MISO in, and is held between bytes.
- Transfers are permitted before `init_done`. The controller is responsible for ordering.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE, `sd_sclk`=0, `sd_mosi`=1, `sd_cs_n`=1.
  - `rx_valid`=0, `rx_data`=0, `init_done`=0, `busy`=0.
  - `tx_ready`=1 once reset is released.
- Accept occurs at clock edge T0. From T0+1: `sd_cs_n`=0, `sd_mosi`=bit7, `sd_sclk`=0.
- SCLK edges, with D = latched divider:
  - Rising edges at T0+D·(2k+1) for k = 0..7.
  - Falling edges at T0+D·(2k+2).
  - MISO is sampled in the cycle SCLK rises.
- Byte end is at T0+16·D:
  - FSM is back in IDLE, `rx_valid`=1 for one cycle, and `rx_data` is final.
  - `tx_ready`=1 in that same cycle, so back-to-back accept is allowed with zero gap.
- INIT: 2·SLOW_DIV·INIT_CLOCKS cycles from the start edge to `init_done`.
- Reset asserted mid-INIT or mid-XFER: all outputs take their reset values immediately. The partial byte is discarded and no `rx_valid` is issued.
- The divider counter is ⌈log2(max(SLOW_DIV,FAST_DIV))⌉ bits wide and wraps to 0 at D−1. The bit counter is 3 bits; the init counter is ⌈log2(INIT_CLOCKS)⌉+1 bits.

## Structure
- Package `sd_pkg` holds:
  - The `sd_spi_state_t` enum (IDLE, INIT, XFER).
  - Default divider and init-clock constants, shared with the SD controller.
- One sub-module, `sd_sclk_gen`:
  - Half-period counter with `run`, a latched divider, and `rise`/`fall` single-cycle strobes.
  - It is the parameterised successor of the fixed 25 MHz enable generator.

## Test plan
- Reset: hold `sys_rst_n`=0, then release. Required: `sd_cs_n`=1, `sd_mosi`=1, `sd_sclk`=0, `tx_ready`=1, `init_done`=0.
- Fast loopback: tie `sd_miso`=`sd_mosi`, `fast_mode`=1, send 0xA5. Required:
  - `rx_valid` exactly 32 cycles after accept, `rx_data`=0xA5.
  - SCLK period 4 cycles, 8 rising edges.
  - `sd_cs_n` high again at byte end.
- Init: pulse `start_init` with `fast_mode`=1. Required: 80 SCLK periods of 250 cycles each with CS and MOSI high, then `init_done`=1 at cycle 20000.
- CS hold: send 0xFF then 0x00 back-to-back with `cs_hold`=1, then 0. Required: second accept in the same cycle as the first `rx_valid`, `sd_cs_n` low continuously, and high after the second byte.
- Contention: `start_init` and `tx_valid` high together in IDLE. Required: INIT runs, `tx_ready`=0 throughout, then the byte is accepted after `init_done`.
- Mid-byte reset: assert `sys_rst_n`=0 at bit 3. Required: all outputs at reset values in the same cycle and no `rx_valid`.
